// File: rtl/id_ex_stage_pkg.sv
// ============================================================================
// id_ex_stage_pkg
// Shared constants for the ID/EX pipeline slice:
//   - RISC-V base opcode constants used by the decode side of the core
//   - ResultSrc encodings (ALU / MEM / PC+4)
//   - zero-register index
//   - packed control bundle carried from decode into execute
// ============================================================================
package id_ex_stage_pkg;

    // Base opcodes (RV32I) shared with the control unit
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Writeback result selection
    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;

    // x0 is hardwired to zero and never produces a hazard
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Control fields travelling with an instruction from decode to execute
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src;
        logic       op5;
        logic       load_byte;
        logic [1:0] result_src;
        logic [2:0] alu_control;
    } ctrl_t;

endpackage : id_ex_stage_pkg

// File: rtl/hazard_detect.sv
// ============================================================================
// hazard_detect
// Combinational load-use comparator. Flags a stall when the instruction in
// execute is a valid load writing a non-zero register that the instruction
// in decode names as rs1 or rs2.
// Ports:
//   valid_e      in   execute slot holds a real instruction
//   result_src_e in   execute-stage result select
//   rd_e         in   execute-stage destination register
//   rs1_d, rs2_d in   decode-stage source registers
//   lw_stall     out  load-use hazard detected
// ============================================================================
module hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic       valid_e,
    input  logic [1:0] result_src_e,
    input  logic [4:0] rd_e,
    input  logic [4:0] rs1_d,
    input  logic [4:0] rs2_d,
    output logic       lw_stall
);

    logic is_load;
    logic dest_live;
    logic src_match;

    // Sources are compared whether or not the instruction actually reads
    // them; a spurious stall costs one cycle, a missed one corrupts data.
    always_comb begin
        is_load   = valid_e && (result_src_e == RESULT_MEM);
        dest_live = (rd_e != REG_ZERO);
        src_match = (rd_e == rs1_d) || (rd_e == rs2_d);
        lw_stall  = is_load && dest_live && src_match;
    end

endmodule : hazard_detect

// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage
// ID/EX pipeline register with load-use stall / branch flush control and
// saturating event counters.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   *D                         decode-stage control, operands, register ids
//   ValidD                     decode slot holds a real instruction
//   PCSrcE                     execute stage redirects the PC
//   *E, ValidE                 registered execute-stage copies
//   StallF, StallD             hold fetch PC and IF/ID register
//   FlushD                     clear IF/ID register
//   BubbleCount, FlushCount    saturating counts of load-use bubbles and
//                              branch/jump flushes
// ============================================================================
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic            JumpD,
    input  logic            BranchD,
    input  logic            ALUSrcD,
    input  logic            Op5D,
    input  logic            LoadByteD,
    input  logic [1:0]      ResultSrcD,
    input  logic [2:0]      ALUControlD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      RdD,
    input  logic            ValidD,
    input  logic            PCSrcE,

    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic            ALUSrcE,
    output logic            Op5E,
    output logic            LoadByteE,
    output logic [1:0]      ResultSrcE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic            ValidE,

    output logic            StallF,
    output logic            StallD,
    output logic            FlushD,

    output logic [CNTW-1:0] BubbleCount,
    output logic [CNTW-1:0] FlushCount
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    logic  lw_stall;
    logic  flush_e;
    logic  stall;
    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    hazard_detect u_hazard_detect (
        .valid_e      (ValidE),
        .result_src_e (ResultSrcE),
        .rd_e         (RdE),
        .rs1_d        (Rs1D),
        .rs2_d        (Rs2D),
        .lw_stall     (lw_stall)
    );

    // A redirect overrides a load-use stall: the decode instruction is
    // being thrown away, so there is nothing to hold.
    always_comb begin
        stall   = lw_stall && !PCSrcE;
        flush_e = PCSrcE || lw_stall;
        StallF  = stall;
        StallD  = stall;
        FlushD  = PCSrcE;
    end

    // Side-effecting controls are dropped for an empty decode slot so a
    // non-instruction can never write the register file, memory or PC.
    always_comb begin
        ctrl_d             = '0;
        ctrl_d.reg_write   = RegWriteD && ValidD;
        ctrl_d.mem_write   = MemWriteD && ValidD;
        ctrl_d.jump        = JumpD     && ValidD;
        ctrl_d.branch      = BranchD   && ValidD;
        ctrl_d.alu_src     = ALUSrcD;
        ctrl_d.op5         = Op5D;
        ctrl_d.load_byte   = LoadByteD;
        ctrl_d.result_src  = ResultSrcD;
        ctrl_d.alu_control = ALUControlD;
    end

    // Pipeline register: a flush inserts an all-zero bubble, otherwise the
    // decode contents advance one stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q   <= '0;
            RD1E     <= '0;
            RD2E     <= '0;
            PCE      <= '0;
            PCPlus4E <= '0;
            ImmExtE  <= '0;
            Rs1E     <= '0;
            Rs2E     <= '0;
            RdE      <= '0;
            ValidE   <= 1'b0;
        end else if (flush_e) begin
            ctrl_q   <= '0;
            RD1E     <= '0;
            RD2E     <= '0;
            PCE      <= '0;
            PCPlus4E <= '0;
            ImmExtE  <= '0;
            Rs1E     <= '0;
            Rs2E     <= '0;
            RdE      <= '0;
            ValidE   <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            RD1E     <= RD1D;
            RD2E     <= RD2D;
            PCE      <= PCD;
            PCPlus4E <= PCPlus4D;
            ImmExtE  <= ImmExtD;
            Rs1E     <= Rs1D;
            Rs2E     <= Rs2D;
            RdE      <= RdD;
            ValidE   <= ValidD;
        end
    end

    always_comb begin
        RegWriteE   = ctrl_q.reg_write;
        MemWriteE   = ctrl_q.mem_write;
        JumpE       = ctrl_q.jump;
        BranchE     = ctrl_q.branch;
        ALUSrcE     = ctrl_q.alu_src;
        Op5E        = ctrl_q.op5;
        LoadByteE   = ctrl_q.load_byte;
        ResultSrcE  = ctrl_q.result_src;
        ALUControlE = ctrl_q.alu_control;
    end

    // Event counters stick at all-ones so a long run never reads as a
    // small count after wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            BubbleCount <= '0;
            FlushCount  <= '0;
        end else begin
            if (stall && (BubbleCount != CNT_MAX)) begin
                BubbleCount <= BubbleCount + CNT_ONE;
            end
            if (PCSrcE && (FlushCount != CNT_MAX)) begin
                FlushCount <= FlushCount + CNT_ONE;
            end
        end
    end

endmodule : id_ex_stage

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// tb_id_ex_stage
// Table-driven self-checking bench for id_ex_stage with a scoreboard queue
// of expected execute-stage contents, plus hand sequences for asynchronous
// reset and counter saturation.
// ============================================================================
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, Op5D, LoadByteD;
    logic [1:0]  ResultSrcD;
    logic [2:0]  ALUControlD;
    logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic        ValidD, PCSrcE;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, Op5E, LoadByteE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic        ValidE, StallF, StallD, FlushD;
    logic [15:0] BubbleCount, FlushCount;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD),
        .BranchD(BranchD), .ALUSrcD(ALUSrcD), .Op5D(Op5D),
        .LoadByteD(LoadByteD), .ResultSrcD(ResultSrcD),
        .ALUControlD(ALUControlD), .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .RdD(RdD), .ValidD(ValidD), .PCSrcE(PCSrcE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
        .BranchE(BranchE), .ALUSrcE(ALUSrcE), .Op5E(Op5E),
        .LoadByteE(LoadByteE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .ValidE(ValidE), .StallF(StallF), .StallD(StallD),
        .FlushD(FlushD), .BubbleCount(BubbleCount), .FlushCount(FlushCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [1:0]  rsrc;
        logic        rw;
        logic        mw;
        logic        jb;
        logic [31:0] imm;
        logic        pcsrc;
        logic        exp_stall;
    } vec_t;

    typedef struct {
        logic        valid_e;
        logic        reg_write;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic        alu_src;
        logic        op5;
        logic        load_byte;
        logic [1:0]  result_src;
        logic [2:0]  alu_ctrl;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] pcplus4;
    } exp_t;

    vec_t        vecs[13];
    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] bubble_model = '0;
    logic [15:0] flush_model = '0;

    // One comparison: counted, and reported only when it disagrees
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Operand fields not named in the table are derived from the vector index
    function automatic logic [31:0] pcOf(input int idx);
        return 32'h0000_1000 + 32'(idx) * 32'd4;
    endfunction

    task automatic applyStimulus(input vec_t v, input int idx);
        logic [31:0] k;
        k           = 32'(idx);
        ValidD      = v.valid;
        RdD         = v.rd;
        Rs1D        = v.rs1;
        Rs2D        = v.rs2;
        ResultSrcD  = v.rsrc;
        RegWriteD   = v.rw;
        MemWriteD   = v.mw;
        JumpD       = v.jb;
        BranchD     = v.jb;
        ImmExtD     = v.imm;
        PCSrcE      = v.pcsrc;
        RD1D        = 32'hA5A5_0000 | k;
        RD2D        = 32'h5A5A_0000 | k;
        PCD         = pcOf(idx);
        PCPlus4D    = pcOf(idx) + 32'd4;
        ALUControlD = k[2:0];
        ALUSrcD     = k[0];
        Op5D        = k[1];
        LoadByteD   = k[2];
    endtask

    // Reference model of what execute holds after the edge
    function automatic exp_t modelE(input vec_t v, input int idx);
        exp_t        e;
        logic [31:0] k;
        k = 32'(idx);
        e = '{default: '0};
        if (!(v.exp_stall || v.pcsrc)) begin
            e.valid_e    = v.valid;
            e.reg_write  = v.rw & v.valid;
            e.mem_write  = v.mw & v.valid;
            e.jump       = v.jb & v.valid;
            e.branch     = v.jb & v.valid;
            e.alu_src    = k[0];
            e.op5        = k[1];
            e.load_byte  = k[2];
            e.result_src = v.rsrc;
            e.alu_ctrl   = k[2:0];
            e.rd         = v.rd;
            e.rs1        = v.rs1;
            e.rs2        = v.rs2;
            e.imm        = v.imm;
            e.rd1        = 32'hA5A5_0000 | k;
            e.rd2        = 32'h5A5A_0000 | k;
            e.pc         = pcOf(idx);
            e.pcplus4    = pcOf(idx) + 32'd4;
        end
        return e;
    endfunction

    task automatic compareE(input exp_t e);
        checkOutput("ValidE",      ValidE,      e.valid_e);
        checkOutput("RegWriteE",   RegWriteE,   e.reg_write);
        checkOutput("MemWriteE",   MemWriteE,   e.mem_write);
        checkOutput("JumpE",       JumpE,       e.jump);
        checkOutput("BranchE",     BranchE,     e.branch);
        checkOutput("ALUSrcE",     ALUSrcE,     e.alu_src);
        checkOutput("Op5E",        Op5E,        e.op5);
        checkOutput("LoadByteE",   LoadByteE,   e.load_byte);
        checkOutput("ResultSrcE",  ResultSrcE,  e.result_src);
        checkOutput("ALUControlE", ALUControlE, e.alu_ctrl);
        checkOutput("RdE",         RdE,         e.rd);
        checkOutput("Rs1E",        Rs1E,        e.rs1);
        checkOutput("Rs2E",        Rs2E,        e.rs2);
        checkOutput("ImmExtE",     ImmExtE,     e.imm);
        checkOutput("RD1E",        RD1E,        e.rd1);
        checkOutput("RD2E",        RD2E,        e.rd2);
        checkOutput("PCE",         PCE,         e.pc);
        checkOutput("PCPlus4E",    PCPlus4E,    e.pcplus4);
    endtask

    // Drive one vector, check the combinational hazard outputs, then check
    // execute contents and counters after the following edge.
    task automatic runVector(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        applyStimulus(v, idx);
        #1;
        checkOutput($sformatf("StallF[%0d]", idx), StallF, v.exp_stall);
        checkOutput($sformatf("StallD[%0d]", idx), StallD, v.exp_stall);
        checkOutput($sformatf("FlushD[%0d]", idx), FlushD, v.pcsrc);
        sb.push_back(modelE(v, idx));
        if (v.exp_stall && bubble_model != 16'hFFFF) bubble_model++;
        if (v.pcsrc && flush_model != 16'hFFFF) flush_model++;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checkOutput("scoreboard_empty", 1'b1, 1'b0);
        end else begin
            e = sb.pop_front();
            compareE(e);
        end
        checkOutput($sformatf("BubbleCount[%0d]", idx), BubbleCount, bubble_model);
        checkOutput($sformatf("FlushCount[%0d]", idx),  FlushCount,  flush_model);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ValidE"},      ValidE,      1'b0);
        checkOutput({tag, "_RegWriteE"},   RegWriteE,   1'b0);
        checkOutput({tag, "_MemWriteE"},   MemWriteE,   1'b0);
        checkOutput({tag, "_RdE"},         RdE,         5'd0);
        checkOutput({tag, "_ImmExtE"},     ImmExtE,     32'd0);
        checkOutput({tag, "_RD1E"},        RD1E,        32'd0);
        checkOutput({tag, "_ResultSrcE"},  ResultSrcE,  2'd0);
        checkOutput({tag, "_BubbleCount"}, BubbleCount, 16'd0);
        checkOutput({tag, "_FlushCount"},  FlushCount,  16'd0);
    endtask

    initial begin
        vec_t fl;
        //          valid rd  rs1 rs2 rsrc   rw mw jb imm        pcsrc stall
        vecs[0]  = '{1'b1, 5,  1,  2, 2'b00, 1, 0, 0, 32'h10, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 7,  3,  4, 2'b01, 1, 0, 0, 32'h04, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8,  1,  7, 2'b00, 1, 0, 0, 32'h20, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 8,  1,  7, 2'b00, 1, 0, 0, 32'h20, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 0,  2,  3, 2'b01, 1, 0, 0, 32'h08, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 9,  0,  6, 2'b00, 1, 0, 0, 32'h30, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 10, 1,  2, 2'b00, 0, 1, 0, 32'h40, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 11, 1,  2, 2'b01, 1, 1, 1, 32'h50, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 12, 11, 2, 2'b01, 1, 0, 0, 32'h60, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 14, 12, 3, 2'b00, 1, 0, 1, 32'h70, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 13, 12, 3, 2'b01, 1, 0, 0, 32'h80, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 15, 5, 13, 2'b00, 0, 1, 1, 32'h90, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 15, 5, 13, 2'b00, 0, 1, 1, 32'h90, 1'b0, 1'b0};

        // Reset asserted from time zero, inputs busy; nothing may be captured
        rst_n = 1'b0;
        applyStimulus(vecs[0], 0);
        #2;
        checkAllZero("reset_async");
        @(posedge clk);
        #1;
        checkAllZero("reset_held");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            runVector(vecs[i], i);
        end

        // Mid-cycle reset with a valid instruction sitting in execute
        runVector(vecs[0], 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("reset_mid");
        bubble_model = '0;
        flush_model  = '0;
        #1;
        rst_n = 1'b1;
        runVector(vecs[5], 5);

        // Drive the flush counter up to 0xFFFE, then past saturation
        fl = vecs[6];
        @(negedge clk);
        applyStimulus(fl, 6);
        repeat (65534) @(posedge clk);
        #1;
        flush_model = 16'hFFFE;
        checkOutput("FlushCount_preload", FlushCount, flush_model);
        for (int i = 0; i < 3; i++) begin
            runVector(fl, 6);
        end
        checkOutput("FlushCount_sat", FlushCount, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_id_ex_stage
